// File: rtl/dsky_relay_latch_pkg.sv
// Shared constants and types for the DSKY relay-matrix reconstruction.
package agc_dsky_pkg;

  localparam int unsigned DSKY_ROWS = 12;

  typedef logic [10:0] row_word_t;
  typedef logic [4:0]  relay_code_t;

  localparam relay_code_t CODE_BLANK = 5'b00000;
  localparam relay_code_t CODE_0     = 5'b10101;
  localparam relay_code_t CODE_1     = 5'b00011;
  localparam relay_code_t CODE_2     = 5'b11001;
  localparam relay_code_t CODE_3     = 5'b11011;
  localparam relay_code_t CODE_4     = 5'b01111;
  localparam relay_code_t CODE_5     = 5'b11110;
  localparam relay_code_t CODE_6     = 5'b11100;
  localparam relay_code_t CODE_7     = 5'b10011;
  localparam relay_code_t CODE_8     = 5'b11101;
  localparam relay_code_t CODE_9     = 5'b11111;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_BAD   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_COMMIT,
    ST_HELD
  } settle_state_t;

  function automatic logic row_valid(input logic [3:0] r);
    return (r != 4'd0) && (r <= 4'(DSKY_ROWS));
  endfunction

endpackage

// File: rtl/dsky_relay_latch_if.sv
// AGC relay inputs, host readout port and change-mask signals of the relay latch.
interface dsky_relay_latch_if;
  import agc_dsky_pkg::*;

  logic [10:0]          rlyb;
  logic [3:0]           rywd;
  logic [3:0]           rd_row;
  row_word_t            rd_data;
  logic [3:0]           rd_left;
  logic [3:0]           rd_right;
  logic                 rd_sign;
  logic                 upd;
  logic [3:0]           upd_row;
  logic [DSKY_ROWS-1:0] dirty;
  logic [DSKY_ROWS-1:0] clr_dirty;

  modport master (
    output rlyb, rywd, rd_row, clr_dirty,
    input  rd_data, rd_left, rd_right, rd_sign, upd, upd_row, dirty
  );

  modport slave (
    input  rlyb, rywd, rd_row, clr_dirty,
    output rd_data, rd_left, rd_right, rd_sign, upd, upd_row, dirty
  );
endinterface

// File: rtl/dsky_relay_digit.sv
// Decodes one 5-bit DSKY relay code into a BCD digit (blank/invalid get marker values).
module dsky_relay_digit
  import agc_dsky_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] digit
);
  always_comb begin
    digit = DIGIT_BAD;
    case (code)
      CODE_BLANK: digit = DIGIT_BLANK;
      CODE_0:     digit = 4'd0;
      CODE_1:     digit = 4'd1;
      CODE_2:     digit = 4'd2;
      CODE_3:     digit = 4'd3;
      CODE_4:     digit = 4'd4;
      CODE_5:     digit = 4'd5;
      CODE_6:     digit = 4'd6;
      CODE_7:     digit = 4'd7;
      CODE_8:     digit = 4'd8;
      CODE_9:     digit = 4'd9;
      default:    digit = DIGIT_BAD;
    endcase
  end
endmodule

// File: rtl/dsky_relay_latch.sv
// Debounces AGC relay words, commits them into the 12-row relay matrix and serves
// a registered, digit-decoded readout plus a per-row change mask.
module dsky_relay_latch
  import agc_dsky_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 5120,
  parameter int unsigned CNT_W         = 16
) (
  input logic               clk,
  input logic               rst_n,
  dsky_relay_latch_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 2);

  settle_state_t        state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [14:0]          word, samp;
  logic                 commit;
  logic [3:0]           c_row;
  logic                 commit_wr;
  logic [DSKY_ROWS-1:0] set_mask;
  row_word_t            rows [16];
  logic                 upd_q;
  logic [3:0]           upd_row_q;
  logic [DSKY_ROWS-1:0] dirty_q;
  row_word_t            rd_q;
  logic                 rd_vld;
  logic [3:0]           left_dig, right_dig;

  assign word      = {bus.rywd, bus.rlyb};
  assign c_row     = samp[14:11];
  assign commit_wr = commit && row_valid(c_row);
  assign set_mask  = (commit_wr && (rows[c_row] != samp[10:0]))
                   ? (DSKY_ROWS'(1) << (c_row - 4'd1)) : '0;

  // The row write is issued on the edge entering COMMIT, so upd is high exactly
  // while the FSM sits in COMMIT; samp follows the input every cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (word != samp) begin
          state_nxt = ST_SETTLING;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLING: begin
        if (word != samp) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          commit    = 1'b1;
          cnt_nxt   = cnt + 1'b1;
          state_nxt = ST_COMMIT;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_COMMIT, ST_HELD: begin
        if (word != samp) begin
          cnt_nxt   = '0;
          state_nxt = ST_SETTLING;
        end else begin
          state_nxt = ST_HELD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      samp  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      samp  <= word;
    end
  end

  // Reads sample the pre-write row contents when they collide with a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) rows[i] <= '0;
      upd_q     <= 1'b0;
      upd_row_q <= '0;
      dirty_q   <= '0;
      rd_q      <= '0;
      rd_vld    <= 1'b0;
    end else begin
      if (commit_wr) begin
        rows[c_row] <= samp[10:0];
        upd_row_q   <= c_row;
      end
      upd_q   <= commit_wr;
      dirty_q <= (dirty_q & ~bus.clr_dirty) | set_mask;
      rd_vld  <= row_valid(bus.rd_row);
      rd_q    <= row_valid(bus.rd_row) ? rows[bus.rd_row] : '0;
    end
  end

  dsky_relay_digit u_left  (.code(rd_q[9:5]), .digit(left_dig));
  dsky_relay_digit u_right (.code(rd_q[4:0]), .digit(right_dig));

  assign bus.rd_data  = rd_q;
  assign bus.rd_sign  = rd_q[10];
  assign bus.rd_left  = rd_vld ? left_dig  : '0;
  assign bus.rd_right = rd_vld ? right_dig : '0;
  assign bus.upd      = upd_q;
  assign bus.upd_row  = upd_row_q;
  assign bus.dirty    = dirty_q;

endmodule

// File: tb/tb_dsky_relay_latch.sv
// Bench for dsky_relay_latch: run-length reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_dsky_relay_latch;
  localparam int unsigned S = 5120;
  localparam logic [4:0] CODES [10] = '{5'b10101, 5'b00011, 5'b11001, 5'b11011, 5'b01111,
                                       5'b11110, 5'b11100, 5'b10011, 5'b11101, 5'b11111};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsky_relay_latch_if bus ();

  dsky_relay_latch #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc = 0;
  int unsigned dut_upd_cnt = 0;
  int unsigned dut_last_cyc = 0;

  // Reference model state: word seen on the previous edge and how many edges in a row it held.
  logic [14:0]  m_prev;
  int unsigned  m_run;
  logic [10:0]  m_rows [16];
  logic [11:0]  m_dirty;
  logic         m_upd;
  logic [3:0]   m_upd_row;
  logic [10:0]  m_rd;
  logic         m_rd_vld;

  function automatic logic [3:0] ref_digit(input logic [4:0] c);
    if (c == 5'b00000) return 4'hF;
    for (int d = 0; d < 10; d++) if (CODES[d] == c) return 4'(d);
    return 4'hE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    logic [14:0] cur;
    logic [3:0]  r;
    logic [11:0] set;
    if (!rst_n) begin
      m_prev = '0; m_run = 0; m_dirty = '0; m_upd = 1'b0; m_upd_row = '0;
      m_rd = '0; m_rd_vld = 1'b0; cyc = 0;
      for (int i = 0; i < 16; i++) m_rows[i] = '0;
    end else begin
      cyc++;
      cur = {bus.rywd, bus.rlyb};
      if (cur != m_prev) m_run = 1;
      else if (m_run < 32'h7FFF_FFFF) m_run++;
      m_prev = cur;
      r = bus.rd_row;
      m_rd_vld = (r >= 1) && (r <= 12);
      m_rd = m_rd_vld ? m_rows[r] : '0;
      m_upd = 1'b0;
      set = '0;
      r = cur[14:11];
      if (m_run == S && r >= 1 && r <= 12) begin
        m_upd = 1'b1;
        m_upd_row = r;
        if (m_rows[r] != cur[10:0]) set[r-1] = 1'b1;
        m_rows[r] = cur[10:0];
      end
      m_dirty = (m_dirty & ~bus.clr_dirty) | set;
    end
    #1;
    chk("upd", 32'(bus.upd), 32'(m_upd));
    if (m_upd) chk("upd_row", 32'(bus.upd_row), 32'(m_upd_row));
    chk("dirty", 32'(bus.dirty), 32'(m_dirty));
    chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
    chk("rd_sign", 32'(bus.rd_sign), 32'(m_rd[10]));
    chk("rd_left", 32'(bus.rd_left), 32'(m_rd_vld ? ref_digit(m_rd[9:5]) : 4'h0));
    chk("rd_right", 32'(bus.rd_right), 32'(m_rd_vld ? ref_digit(m_rd[4:0]) : 4'h0));
    if (bus.upd) begin
      dut_upd_cnt++;
      dut_last_cyc = cyc;
    end
  end

  task automatic drive(input logic [3:0] row, input logic [10:0] val);
    bus.rywd = row;
    bus.rlyb = val;
  endtask

  task automatic hold(input int unsigned n, input bit rnd = 1'b0);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (rnd) begin
        bus.rd_row = 4'($urandom_range(0, 15));
        bus.clr_dirty = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'h000;
      end
    end
  endtask

  initial begin
    int unsigned c0, n0;
    drive(4'd3, 11'h7FF);
    bus.rd_row = '0;
    bus.clr_dirty = '0;
    repeat (3) @(negedge clk);
    chk("reset_upd", 32'(bus.upd), 32'd0);
    chk("reset_upd_row", 32'(bus.upd_row), 32'd0);
    chk("reset_dirty", 32'(bus.dirty), 32'd0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
    chk("reset_rd_left", 32'(bus.rd_left), 32'd0);

    rst_n = 1'b1;
    hold(S - 1);
    chk("no_early_upd", dut_upd_cnt, 32'd0);
    @(negedge clk);
    chk("first_upd", 32'(bus.upd), 32'd1);
    chk("first_upd_cycle", dut_last_cyc, 32'd5120);
    chk("first_upd_row", 32'(bus.upd_row), 32'd3);
    chk("first_dirty", 32'(bus.dirty), 32'h004);

    drive(4'd1, 11'h33F);
    c0 = cyc;
    hold(S);
    chk("decode_commit_cycle", dut_last_cyc, c0 + S);
    bus.rd_row = 4'd1;
    @(negedge clk);
    chk("decode_left", 32'(bus.rd_left), 32'd2);
    chk("decode_right", 32'(bus.rd_right), 32'd9);
    chk("decode_sign", 32'(bus.rd_sign), 32'd0);
    chk("decode_data", 32'(bus.rd_data), 32'h33F);

    drive(4'd5, 11'h2AA);
    hold(3000);
    drive(4'd5, 11'h0F0);
    hold(1);
    drive(4'd5, 11'h2AA);
    c0 = cyc;
    n0 = dut_upd_cnt;
    hold(S + 20);
    chk("glitch_one_upd", dut_upd_cnt, n0 + 1);
    chk("glitch_upd_cycle", dut_last_cyc, c0 + S);
    bus.rd_row = 4'd5;
    @(negedge clk);
    chk("glitch_value", 32'(bus.rd_data), 32'h2AA);

    n0 = dut_upd_cnt;
    drive(4'd0, 11'h123);
    hold(S + 10);
    drive(4'd14, 11'h456);
    hold(S + 10);
    chk("invalid_row_no_upd", dut_upd_cnt, n0);
    chk("invalid_row_dirty", 32'(bus.dirty), 32'h015);
    chk("invalid_row_keep5", 32'(bus.rd_data), 32'h2AA);

    drive(4'd7, {1'b1, 5'b01010, 5'b10101});
    hold(S);
    bus.rd_row = 4'd7;
    @(negedge clk);
    chk("bad_code_left", 32'(bus.rd_left), 32'hE);
    chk("bad_code_right", 32'(bus.rd_right), 32'h0);
    chk("bad_code_sign", 32'(bus.rd_sign), 32'd1);

    bus.clr_dirty = '1;
    @(negedge clk);
    bus.clr_dirty = '0;
    chk("clear_all_dirty", 32'(bus.dirty), 32'h000);
    drive(4'd2, 11'h1C3);
    hold(S);
    chk("row2_dirty_set", 32'(bus.dirty), 32'h002);
    bus.clr_dirty = 12'h002;
    @(negedge clk);
    bus.clr_dirty = '0;
    chk("row2_dirty_clr", 32'(bus.dirty), 32'h000);
    drive(4'd2, 11'h3C3);
    hold(100);
    drive(4'd2, 11'h1C3);
    n0 = dut_upd_cnt;
    hold(S);
    chk("same_value_upd", dut_upd_cnt, n0 + 1);
    chk("same_value_upd_row", 32'(bus.upd_row), 32'd2);
    chk("same_value_not_dirty", 32'(bus.dirty), 32'h000);

    drive(4'd2, 11'h07E);
    hold(S - 1);
    bus.clr_dirty = 12'h002;
    @(negedge clk);
    bus.clr_dirty = '0;
    chk("set_wins_upd", 32'(bus.upd), 32'd1);
    chk("set_wins_dirty", 32'(bus.dirty), 32'h002);

    drive(4'd4, 11'h155);
    bus.rd_row = 4'd4;
    hold(S);
    chk("collision_upd", 32'(bus.upd), 32'd1);
    chk("collision_old", 32'(bus.rd_data), 32'h000);
    @(negedge clk);
    chk("collision_new", 32'(bus.rd_data), 32'h155);

    drive(4'd6, 11'h6B5);
    hold(2000);
    n0 = dut_upd_cnt;
    rst_n = 1'b0;
    hold(3);
    drive(4'd0, 11'h000);
    rst_n = 1'b1;
    hold(S + 10);
    chk("reset_discard_no_upd", dut_upd_cnt, n0);
    bus.rd_row = 4'd6;
    @(negedge clk);
    chk("reset_discard_row6", 32'(bus.rd_data), 32'h000);

    for (int unsigned i = 0; i < 12; i++) begin
      drive(4'($urandom_range(0, 15)), 11'($urandom));
      if (i % 4 == 3) hold(S - 1 + $urandom_range(0, 3), 1'b1);
      else hold($urandom_range(1, 40), 1'b1);
    end
    hold(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
